// File: rtl/fact_cu.sv
// Moore control unit sequencing the 4-bit factorial datapath (load, check, multiply).
// Optional saturating busy-cycle counter on output `cycles` when FACT_CU_CYCLE_CNT_EN is defined.
module fact_cu #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             gt_in,
  input  logic             gt_fact,
  output logic             load_cnt,
  output logic             en,
  output logic             sel_1,
  output logic             load_reg,
  output logic             sel_2,
  output logic             done,
  output logic             err
`ifdef FACT_CU_CYCLE_CNT_EN
  ,
  output logic [CNT_W-1:0] cycles
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    CHECK = 3'd2,
    MUL   = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t state, state_nxt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: the default assignment before the case keeps this block purely
  // combinational; a path that leaves state_nxt unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (go) state_nxt = gt_in ? ERR : INIT;
      INIT:    state_nxt = CHECK;
      CHECK:   state_nxt = gt_fact ? MUL : DONE;
      MUL:     state_nxt = CHECK;
      DONE:    if (!go) state_nxt = IDLE;
      ERR:     if (!go) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_cnt = 1'b0;
    en       = 1'b0;
    sel_1    = 1'b0;
    load_reg = 1'b0;
    sel_2    = 1'b1;
    done     = 1'b0;
    err      = 1'b0;
    unique case (state)
      INIT: begin
        load_cnt = 1'b1;
        sel_1    = 1'b1;
        load_reg = 1'b1;
      end
      MUL: begin
        load_reg = 1'b1;
        en       = 1'b1;
      end
      DONE: begin
        done  = 1'b1;
        sel_2 = 1'b0;
      end
      ERR:     err = 1'b1;
      default: ;
    endcase
  end

`ifdef FACT_CU_CYCLE_CNT_EN
  // Counts INIT/CHECK/MUL cycles of the latest accepted request; holds otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cycles <= '0;
    end else if (state == IDLE && state_nxt == INIT) begin
      cycles <= '0;
    end else if ((state == INIT || state == CHECK || state == MUL) && cycles != '1) begin
      cycles <= cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fact_cu.sv
// Self-checking bench for fact_cu: a behavioural datapath stands in for fact_dp, and
// expected latency/result/err come from the factorial rules using plain arithmetic.
module tb_fact_cu;

  logic       clk = 1'b0;
  logic       rst;
  logic       go;
  logic       gt_in;
  logic       gt_fact;
  logic       load_cnt, en, sel_1, load_reg, sel_2, done, err;
`ifdef FACT_CU_CYCLE_CNT_EN
  logic [7:0] cycles;
`endif

  int checks   = 0;
  int failures = 0;

  logic [3:0] n;
  logic [3:0] dp_cnt;
  logic [3:0] dp_prod;
  logic [3:0] nf;

  always #5 clk = ~clk;

  fact_cu #(.CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .gt_in    (gt_in),
    .gt_fact  (gt_fact),
    .load_cnt (load_cnt),
    .en       (en),
    .sel_1    (sel_1),
    .load_reg (load_reg),
    .sel_2    (sel_2),
    .done     (done),
    .err      (err)
`ifdef FACT_CU_CYCLE_CNT_EN
    ,
    .cycles   (cycles)
`endif
  );

  // Stand-in for fact_dp: responds to the strobes, never reset.
  always @(posedge clk) begin
    if (load_cnt)  dp_cnt <= n;
    else if (en)   dp_cnt <= dp_cnt - 4'd1;
    if (load_reg)  dp_prod <= sel_1 ? 4'd1 : 4'(dp_prod * dp_cnt);
  end

  assign gt_in   = (n > 4'd12);
  assign gt_fact = (dp_cnt > 4'd1);
  assign nf      = sel_2 ? 4'd0 : dp_prod;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int fact_mod16(input int v);
    int p = 1;
    for (int i = 2; i <= v; i++) p = p * i;
    return p % 16;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_strobes"}, {load_cnt, en, sel_1, load_reg}, 4'b0000);
    check({tag, "_sel_2"}, sel_2, 1'b1);
    check({tag, "_done_err"}, {done, err}, 2'b00);
  endtask

  // One request: go rises at a negedge; k counts edges until done/err shows.
  task automatic run(input int nv, input bit hold, input int linger);
    int k, muls, lat;
    @(negedge clk);
    n  = 4'(nv);
    go = 1'b1;
    k = 0;
    muls = 0;
    do begin
      @(negedge clk);
      k++;
      if (!hold) go = (k == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      if (en) muls++;
    end while (!done && !err && k < 60);
    check($sformatf("both_hi_n%0d", nv), done & err, 1'b0);
    if (nv > 12) begin
      check($sformatf("err_lat_n%0d", nv), k, 1);
      check($sformatf("err_n%0d", nv), err, 1'b1);
    end else begin
      lat = (nv <= 1) ? 2 : 2 * nv;
      check($sformatf("done_lat_n%0d", nv), k, lat + 1);
      check($sformatf("muls_n%0d", nv), muls, (nv <= 1) ? 0 : nv - 1);
      check($sformatf("nf_n%0d", nv), nf, fact_mod16(nv));
`ifdef FACT_CU_CYCLE_CNT_EN
      check($sformatf("cycles_n%0d", nv), cycles, lat);
`endif
    end
    go = 1'b1;
    for (int i = 0; i < linger; i++) begin
      @(negedge clk);
      check($sformatf("hold_flag_n%0d", nv), {done, err}, (nv > 12) ? 2'b01 : 2'b10);
      check($sformatf("hold_strobes_n%0d", nv), {load_cnt, en, load_reg}, 3'b000);
    end
    go = 1'b0;
    @(negedge clk);
    check_idle($sformatf("back_idle_n%0d", nv));
  endtask

  initial begin
    int en_seen;
    logic [7:0] saved;
    rst = 1'b0;
    go  = 1'b1;
    n   = 4'd3;
    repeat (2) begin
      @(negedge clk);
      check_idle("reset");
    end
    go  = 1'b0;
    @(negedge clk);
    check_idle("reset_release_pre");
    rst = 1'b1;
    @(negedge clk);
    check_idle("after_reset");
`ifdef FACT_CU_CYCLE_CNT_EN
    check("cycles_reset", cycles, 0);
`endif

    run(3, 1'b0, 0);
    run(0, 1'b0, 0);
    run(1, 1'b0, 0);
    run(12, 1'b0, 0);
`ifdef FACT_CU_CYCLE_CNT_EN
    run(3, 1'b0, 0);
    saved = cycles;
    run(13, 1'b1, 3);
    check("cycles_after_err", cycles, saved);
`else
    run(13, 1'b1, 3);
`endif
    run(5, 1'b1, 4);

    // New request after done, then reset during the second MUL.
    @(negedge clk);
    n  = 4'd5;
    go = 1'b1;
    en_seen = 0;
    for (int i = 0; i < 30 && en_seen < 2; i++) begin
      @(negedge clk);
      if (i == 0) check("restart_init", {load_cnt, sel_1, load_reg}, 3'b111);
      if (en) en_seen++;
    end
    check("mul2_reached", en_seen, 2);
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset_mid_mul");
    go  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_idle("post_reset_idle");

    for (int r = 0; r < 12; r++) begin
      run(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
